// File: rtl/systolic_array_gen_pkg.sv
// Shared types and helpers for the systolic matrix-multiply block.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Result of the shift/saturate helper; val is sized for the widest operand
  // the helper supports, callers keep the low BIT_WIDTH bits.
  typedef struct packed {
    logic        sat;
    logic [63:0] val;
  } sat_res_t;

  // Accumulator width: full product plus growth for K_MAX additions.
  function automatic int acc_width(input int bw, input int kmax);
    return 2 * bw + $clog2(kmax + 1);
  endfunction

  // Arithmetic shift right by frac_w (floor), then clamp to a signed bit_w range.
  function automatic sat_res_t sat_shift(input logic signed [127:0] acc,
                                         input int frac_w,
                                         input int bit_w);
    logic signed [127:0] sh;
    logic signed [127:0] max_v;
    logic signed [127:0] min_v;
    sat_res_t            r;
    sh    = acc >>> frac_w;
    max_v = (128'sd1 <<< (bit_w - 1)) - 128'sd1;
    min_v = -(128'sd1 <<< (bit_w - 1));
    if (sh > max_v) begin
      r.sat = 1'b1;
      r.val = max_v[63:0];
    end else if (sh < min_v) begin
      r.sat = 1'b1;
      r.val = min_v[63:0];
    end else begin
      r.sat = 1'b0;
      r.val = sh[63:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/systolic_array_gen_pe_mac.sv
// One processing element: forwards operands east/south through one register
// each and accumulates their full-precision product.
module pe_mac
  import systolic_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int ACC_W     = acc_width(16, 64)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [BIT_WIDTH-1:0] a_in,
  input  logic [BIT_WIDTH-1:0] b_in,
  output logic [BIT_WIDTH-1:0] a_out,
  output logic [BIT_WIDTH-1:0] b_out,
  output logic [ACC_W-1:0]     acc
);

  logic [BIT_WIDTH-1:0]          a_q, a_d;
  logic [BIT_WIDTH-1:0]          b_q, b_d;
  logic [ACC_W-1:0]              acc_q, acc_d;
  logic signed [2*BIT_WIDTH-1:0] prod;

  // Next-state: forward operands, add sign-extended product unless clearing.
  always_comb begin
    prod  = $signed(a_in) * $signed(b_in);
    a_d   = a_in;
    b_d   = b_in;
    acc_d = clr ? '0
                : acc_q + {{(ACC_W-2*BIT_WIDTH){prod[2*BIT_WIDTH-1]}}, prod};
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_array_gen.sv
// Output-stationary ROWS x COLS systolic array computing C = A * B in
// signed fixed point. A columns enter from the west, B rows from the north,
// unskewed; the block skews them internally, flushes, then drains one result
// row per handshake.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds its data and valid stable until that edge,
// and ready may change freely.
module systolic_array_gen
  import systolic_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int ROWS       = 32,
  parameter int COLS       = 4,
  parameter int K_MAX      = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(K_MAX+1)-1:0]    k_len,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROWS*BIT_WIDTH-1:0]     west_in,
  input  logic [COLS*BIT_WIDTH-1:0]     north_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COLS*BIT_WIDTH-1:0]     out_row,
  output logic [$clog2(ROWS)-1:0]       out_idx,
  output logic                          busy,
  output logic                          done,
  output logic                          sat,
  output state_t                        dbg_state
);

  localparam int KW    = $clog2(K_MAX + 1);
  localparam int IW    = $clog2(ROWS);
  localparam int FCW   = $clog2(ROWS + COLS);
  localparam int ACC_W = acc_width(BIT_WIDTH, K_MAX);

  state_t                     state_q, state_d;
  logic [KW-1:0]              klen_q, klen_d;
  logic [KW-1:0]              kcnt_q, kcnt_d;
  logic [FCW-1:0]             fcnt_q, fcnt_d;
  logic [IW-1:0]              ld_q, ld_d;
  logic                       out_valid_q, out_valid_d;
  logic [COLS*BIT_WIDTH-1:0]  out_row_q, out_row_d;
  logic [IW-1:0]              out_idx_q, out_idx_d;
  logic                       in_ready_q, in_ready_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       sat_q, sat_d;

  logic                       start_acc;
  logic                       fire;
  logic                       hs;
  logic [KW-1:0]              k_eff;

  logic [BIT_WIDTH-1:0]       west_inj  [ROWS];
  logic [BIT_WIDTH-1:0]       north_inj [COLS];
  logic [BIT_WIDTH-1:0]       west_sk   [ROWS];
  logic [BIT_WIDTH-1:0]       north_sk  [COLS];
  logic [BIT_WIDTH-1:0]       a_fwd     [ROWS][COLS];
  logic [BIT_WIDTH-1:0]       b_fwd     [ROWS][COLS];
  logic [ACC_W-1:0]           acc_w     [ROWS][COLS];

  logic [COLS*BIT_WIDTH-1:0]  drain_row;
  logic                       drain_sat;
  logic                       unused_hi;
  logic                       unused_edges;

  // Control: job sequencing, slice counting, flush timing and row drain.
  always_comb begin
    start_acc   = (state_q == ST_IDLE) && start;
    fire        = in_ready_q && in_valid;
    hs          = out_valid_q && out_ready;
    k_eff       = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
    state_d     = state_q;
    klen_d      = klen_q;
    kcnt_d      = kcnt_q;
    fcnt_d      = fcnt_q;
    ld_d        = ld_q;
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    out_idx_d   = out_idx_q;
    done_d      = 1'b0;
    sat_d       = sat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          klen_d  = k_eff;
          kcnt_d  = '0;
          fcnt_d  = '0;
          ld_d    = '0;
          sat_d   = 1'b0;
          state_d = (k_eff == '0) ? ST_DRAIN : ST_FEED;
        end
      end
      ST_FEED: begin
        if (fire) begin
          kcnt_d = kcnt_q + 1'b1;
          if (kcnt_q == klen_q - 1'b1) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Last product lands at PE(ROWS-1,COLS-1) ROWS+COLS-2 cycles after
        // the final slice; one extra cycle lets that accumulate register.
        fcnt_d = fcnt_q + 1'b1;
        if (fcnt_q == FCW'(ROWS + COLS - 2)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (hs && (out_idx_q == IW'(ROWS - 1))) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          done_d      = 1'b1;
        end else if (!out_valid_q || hs) begin
          out_valid_d = 1'b1;
          out_row_d   = drain_row;
          out_idx_d   = ld_q;
          ld_d        = ld_q + 1'b1;
          sat_d       = sat_q | drain_sat;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_FEED);
    busy_d     = (state_d != ST_IDLE);
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      klen_q      <= '0;
      kcnt_q      <= '0;
      fcnt_q      <= '0;
      ld_q        <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_idx_q   <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      klen_q      <= klen_d;
      kcnt_q      <= kcnt_d;
      fcnt_q      <= fcnt_d;
      ld_q        <= ld_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_idx_q   <= out_idx_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sat_q       <= sat_d;
    end
  end

  // Edge injection: zeros unless a slice is being accepted, so bubbles add nothing.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      west_inj[i] = fire ? west_in[i*BIT_WIDTH +: BIT_WIDTH] : '0;
    end
    for (int j = 0; j < COLS; j++) begin
      north_inj[j] = fire ? north_in[j*BIT_WIDTH +: BIT_WIDTH] : '0;
    end
  end

  // West skew: lane i delayed by i cycles.
  for (genvar i = 0; i < ROWS; i++) begin : g_wskew
    if (i == 0) begin : g_direct
      assign west_sk[i] = west_inj[i];
    end else begin : g_delay
      logic [BIT_WIDTH-1:0] sr_q [i];
      logic [BIT_WIDTH-1:0] sr_d [i];
      // Shift the lane one stage per cycle.
      always_comb begin
        sr_d[0] = west_inj[i];
        for (int n = 1; n < i; n++) sr_d[n] = sr_q[n-1];
      end
      // Skew stage registers.
      always_ff @(posedge clk) begin
        if (rst) sr_q <= '{default: '0};
        else     sr_q <= sr_d;
      end
      assign west_sk[i] = sr_q[i-1];
    end
  end

  // North skew: lane j delayed by j cycles.
  for (genvar j = 0; j < COLS; j++) begin : g_nskew
    if (j == 0) begin : g_direct
      assign north_sk[j] = north_inj[j];
    end else begin : g_delay
      logic [BIT_WIDTH-1:0] sr_q [j];
      logic [BIT_WIDTH-1:0] sr_d [j];
      // Shift the lane one stage per cycle.
      always_comb begin
        sr_d[0] = north_inj[j];
        for (int n = 1; n < j; n++) sr_d[n] = sr_q[n-1];
      end
      // Skew stage registers.
      always_ff @(posedge clk) begin
        if (rst) sr_q <= '{default: '0};
        else     sr_q <= sr_d;
      end
      assign north_sk[j] = sr_q[j-1];
    end
  end

  // PE grid.
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      logic [BIT_WIDTH-1:0] a_src;
      logic [BIT_WIDTH-1:0] b_src;
      if (j == 0) begin : g_a_edge
        assign a_src = west_sk[i];
      end else begin : g_a_int
        assign a_src = a_fwd[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_src = north_sk[j];
      end else begin : g_b_int
        assign b_src = b_fwd[i-1][j];
      end
      pe_mac #(
        .BIT_WIDTH (BIT_WIDTH),
        .ACC_W     (ACC_W)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .a_in  (a_src),
        .b_in  (b_src),
        .a_out (a_fwd[i][j]),
        .b_out (b_fwd[i][j]),
        .acc   (acc_w[i][j])
      );
    end
  end

  // Drain mux: scale and saturate the row selected by the load pointer.
  always_comb begin
    logic [ACC_W-1:0] a_tmp;
    sat_res_t         res;
    drain_row = '0;
    drain_sat = 1'b0;
    unused_hi = 1'b0;
    for (int j = 0; j < COLS; j++) begin
      a_tmp = acc_w[ld_q][j];
      res   = sat_shift({{(128-ACC_W){a_tmp[ACC_W-1]}}, a_tmp}, FRAC_WIDTH, BIT_WIDTH);
      drain_row[j*BIT_WIDTH +: BIT_WIDTH] = res.val[BIT_WIDTH-1:0];
      drain_sat = drain_sat | res.sat;
      unused_hi = unused_hi ^ (^res.val[63:BIT_WIDTH]);
    end
  end

  // Operands leaving the east and south edges go nowhere.
  always_comb begin
    unused_edges = 1'b0;
    for (int i = 0; i < ROWS; i++) unused_edges = unused_edges ^ (^a_fwd[i][COLS-1]);
    for (int j = 0; j < COLS; j++) unused_edges = unused_edges ^ (^b_fwd[ROWS-1][j]);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_idx   = out_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sat       = sat_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_systolic_array_gen.sv
// Bench for systolic_array_gen: 4x4 array, matrix-product reference model,
// scoreboard of expected result rows popped by an output monitor.
module tb_systolic_array_gen;
  import systolic_pkg::*;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int BW = 16;
  localparam int FB = 8;
  localparam int KM = 64;
  localparam int KW = 7;
  localparam int IW = 2;

  logic              clk;
  logic              rst;
  logic              start;
  logic [KW-1:0]     k_len;
  logic              in_valid;
  logic              in_ready;
  logic [R*BW-1:0]   west_in;
  logic [C*BW-1:0]   north_in;
  logic              out_valid;
  logic              out_ready;
  logic [C*BW-1:0]   out_row;
  logic [IW-1:0]     out_idx;
  logic              busy;
  logic              done;
  logic              sat;
  state_t            dbg_state;

  systolic_array_gen #(
    .BIT_WIDTH (BW),
    .FRAC_WIDTH(FB),
    .ROWS      (R),
    .COLS      (C),
    .K_MAX     (KM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .k_len    (k_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .west_in  (west_in),
    .north_in (north_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_row  (out_row),
    .out_idx  (out_idx),
    .busy     (busy),
    .done     (done),
    .sat      (sat),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int                total = 0;
  int                bad   = 0;
  logic [C*BW-1:0]   exp_q[$];
  logic [IW-1:0]     exp_idx_q[$];
  bit                exp_sat;
  int                ma [R][KM];
  int                mb [KM][C];
  int                stall_mode = 0;
  int                stall_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain matrix product, floor-shift, clamp.
  task automatic push_expected(input int ke);
    logic [C*BW-1:0] row;
    longint          s;
    exp_sat = 1'b0;
    for (int i = 0; i < R; i++) begin
      row = '0;
      for (int j = 0; j < C; j++) begin
        s = 0;
        for (int k = 0; k < ke; k++) s += longint'(ma[i][k]) * longint'(mb[k][j]);
        s = s >>> FB;
        if (s > 32767) begin
          s = 32767;
          exp_sat = 1'b1;
        end else if (s < -32768) begin
          s = -32768;
          exp_sat = 1'b1;
        end
        row[j*BW +: BW] = s[15:0];
      end
      exp_q.push_back(row);
      exp_idx_q.push_back(IW'(i));
    end
  endtask

  // ---------------- operand generators ----------------
  task automatic fill_identity_ramp();
    for (int i = 0; i < R; i++)
      for (int k = 0; k < KM; k++) ma[i][k] = (i == k) ? 256 : 0;
    for (int k = 0; k < KM; k++)
      for (int j = 0; j < C; j++) mb[k][j] = 256 * (k + j);
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < R; i++)
      for (int k = 0; k < KM; k++) ma[i][k] = v;
    for (int k = 0; k < KM; k++)
      for (int j = 0; j < C; j++) mb[k][j] = v;
  endtask

  task automatic fill_rand(input bit full);
    for (int i = 0; i < R; i++)
      for (int k = 0; k < KM; k++)
        ma[i][k] = full ? int'(shortint'($urandom_range(0, 65535)))
                        : int'($urandom_range(0, 1023)) - 512;
    for (int k = 0; k < KM; k++)
      for (int j = 0; j < C; j++)
        mb[k][j] = full ? int'(shortint'($urandom_range(0, 65535)))
                        : int'($urandom_range(0, 1023)) - 512;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input int kl);
    @(posedge clk); #1;
    start = 1'b1;
    k_len = KW'(kl);
    @(posedge clk); #1;
    start = 1'b0;
    k_len = KW'($urandom_range(0, 127));
    chk("busy_after_start", busy, 1);
  endtask

  // vmode 0: valid every cycle, 1: every other cycle, 2: random.
  task automatic do_feed(input int nsl, input int vmode);
    int sent = 0;
    int cyc  = 0;
    bit v;
    bit got;
    while (sent < nsl && cyc < 1000) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      in_valid = v;
      for (int i = 0; i < R; i++)
        west_in[i*BW +: BW] = v ? BW'(ma[i][sent]) : BW'($urandom_range(0, 65535));
      for (int j = 0; j < C; j++)
        north_in[j*BW +: BW] = v ? BW'(mb[sent][j]) : BW'($urandom_range(0, 65535));
      @(negedge clk);
      got = v && in_ready;
      @(posedge clk); #1;
      if (got) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    if (sent < nsl) chk("feed_timeout", 64'(sent), 64'(nsl));
  endtask

  task automatic wait_done(input bit poke, input bit sat_exp);
    int cyc    = 0;
    bit seen   = 0;
    bit poked  = 0;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (poke && !poked && out_valid && out_idx == '0) begin
        start = 1'b1;
        k_len = KW'(3);
        poked = 1'b1;
      end else start = 1'b0;
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", 64'(seen), 64'(1));
    chk("busy_after_done", busy, 0);
    chk("sat_flag", sat, sat_exp);
    if (poke) begin
      chk("poke_issued", 64'(poked), 64'(1));
      repeat (3) @(negedge clk);
      chk("start_in_drain_ignored", busy, 0);
    end
  endtask

  task automatic run_job(input int kl, input int vmode, input int smode, input bit poke);
    int ke;
    ke = (kl > KM) ? KM : kl;
    push_expected(ke);
    stall_mode = smode;
    stall_cnt  = 0;
    do_start(kl);
    if (ke > 0) do_feed(ke, vmode);
    wait_done(poke, exp_sat);
    if (smode == 1) chk("stall_cycles_row1", 64'(stall_cnt), 64'(5));
    stall_mode = 0;
  endtask

  // ---------------- consumer ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_mode == 1 && out_valid && out_idx == IW'(1) && stall_cnt < 5) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else if (stall_mode == 2) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  bit              prev_stall = 0;
  bit              prev_last  = 0;
  logic [C*BW-1:0] prev_row;
  logic [IW-1:0]   prev_idx;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      prev_last  = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_row", out_row, prev_row);
        chk("hold_idx", out_idx, prev_idx);
      end
      if (prev_last) chk("done_pulse", done, 1);
      else if (done) chk("unexpected_done", done, 0);
      prev_last = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_row", 64'(1), 64'(0));
        end else begin
          chk("row_data", out_row, exp_q.pop_front());
          chk("row_idx", out_idx, exp_idx_q.pop_front());
        end
        prev_last = (out_idx == IW'(R - 1));
      end
      prev_stall = out_valid && !out_ready;
      prev_row   = out_row;
      prev_idx   = out_idx;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    total++;
    bad++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int dones;
    rst      = 1'b1;
    start    = 1'b0;
    k_len    = '0;
    in_valid = 1'b0;
    west_in  = '0;
    north_in = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat, 0);
    rst = 1'b0;

    // Identity times ramp, then with bubbles.
    fill_identity_ramp();
    run_job(4, 0, 0, 0);
    run_job(4, 1, 0, 0);

    // Saturating job, then a clean job must clear sat.
    fill_const(int'(16'sh7F00));
    run_job(2, 0, 0, 0);
    fill_identity_ramp();
    run_job(4, 0, 0, 0);

    // Back-pressure on row 1.
    run_job(4, 0, 1, 0);

    // Reset during FLUSH aborts the job.
    do_start(4);
    do_feed(4, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || out_valid) dones++;
    end
    chk("abort_quiet", 64'(dones), 64'(0));
    run_job(4, 0, 0, 0);

    // Negative operand, with a start poked during DRAIN.
    fill_const(0);
    for (int i = 0; i < R; i++) ma[i][0] = -128;
    for (int j = 0; j < C; j++) mb[0][j] = 256;
    run_job(1, 0, 0, 1);

    // Empty inner dimension.
    fill_rand(1'b1);
    run_job(0, 0, 0, 0);

    // Oversized k_len is clamped to K_MAX.
    fill_rand(1'b0);
    run_job(100, 2, 2, 0);

    // Random jobs.
    for (int n = 0; n < 4; n++) begin
      fill_rand(n[0]);
      run_job(int'($urandom_range(1, 12)), 2, 2, 0);
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_array_gen.md
SYSTOLIC_ARRAY_GEN -- requirements
Module: systolic_array_gen

Interface
REQ-001 Parameter BIT_WIDTH, default 16: signed fixed-point operand and result width.
REQ-002 Parameter FRAC_WIDTH, default 8: fractional bits in operands and results.
REQ-003 Parameter ROWS, default 32: PE rows, equal to result rows per job.
REQ-004 Parameter COLS, default 4: PE columns, equal to result columns per job.
REQ-005 Parameter K_MAX, default 64: maximum inner dimension per job.
REQ-006 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1: reset, synchronous, active-high.
REQ-008 Port start, input, 1: job request, sampled only in IDLE.
REQ-009 Port k_len, input, $clog2(K_MAX+1): inner dimension, captured on accepted start.
REQ-010 Port in_valid, input, 1: west_in and north_in carry one k-slice.
REQ-011 Port in_ready, output, 1: slice accepted when in_valid && in_ready.
REQ-012 Port west_in, input, ROWS*BIT_WIDTH: A column k; lane i is row i, lane 0 in the LSBs.
REQ-013 Port north_in, input, COLS*BIT_WIDTH: B row k; lane j is column j.
REQ-014 Port out_valid, output, 1: out_row and out_idx valid.
REQ-015 Port out_ready, input, 1: consumer accepts a row when out_valid && out_ready.
REQ-016 Port out_row, output, COLS*BIT_WIDTH: one result row C[out_idx][*].
REQ-017 Port out_idx, output, $clog2(ROWS): index of the row on out_row.
REQ-018 Port busy, output, 1: high in every state except IDLE.
REQ-019 Port done, output, 1: one-cycle pulse after the last row handshake.
REQ-020 Port sat, output, 1: sticky per job; set if any emitted element saturated.

Function
REQ-021 FSM states: IDLE, FEED, FLUSH, DRAIN. IDLE->FEED on start (k_len>0); IDLE->DRAIN on start with k_len==0; FEED->FLUSH after the k_len-th accepted slice; FLUSH->DRAIN after ROWS+COLS-1 cycles; DRAIN->IDLE on the handshake of row ROWS-1.
REQ-022 in_ready is high only in FEED.
REQ-023 Skew: the block delays west lane i by i cycles and north lane j by j cycles internally; the caller presents unskewed slices.
REQ-024 Any FEED cycle without a handshake, and every FLUSH cycle, injects zero operands into both edges; bubbles do not alter results.
REQ-025 Each PE(i,j) forwards west data east and north data south with 1-cycle registers and accumulates a*b with no rounding into an accumulator of 2*BIT_WIDTH+$clog2(K_MAX+1) bits.
REQ-026 Result: acc arithmetic-shifted right by FRAC_WIDTH (truncation toward -inf), then saturated to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1].
REQ-027 DRAIN emits rows 0..ROWS-1 in order; the first row appears with out_valid on the cycle after entering DRAIN.
REQ-028 While out_valid && !out_ready, out_row, out_idx and out_valid hold stable.
REQ-029 start is ignored while busy; k_len above K_MAX is clamped to K_MAX.
REQ-030 An accepted start clears all accumulators and sat in the same edge.
REQ-031 k_len==0: all rows emitted as zero, sat stays 0.

Reset
REQ-032 On rst: FSM to IDLE; accumulators, skew and forwarding registers, and counters cleared.
REQ-033 Reset values: in_ready=0, out_valid=0, out_row=0, out_idx=0, busy=0, done=0, sat=0.
REQ-034 Reset mid-job aborts without a done pulse; the next start behaves as the first after power-up.

Structure
REQ-035 Package systolic_pkg holds the FSM state enum, the accumulator-width function, and the saturate/shift helper.
REQ-036 Sub-module pe_mac (one PE: forwarding registers, MAC, clear input) is instantiated ROWS*COLS times by generate loops.

Verification
REQ-037 ROWS=4, COLS=4, k_len=4, A=identity (0x0100), B[k][j]=0x0100*(k+j) -> rows C[i][j]=0x0100*(i+j), done 1 cycle after row 3.
REQ-038 Same job with in_valid toggled every other cycle -> identical out_row values.
REQ-039 k_len=2, all operands 0x7F00 -> every element 0x7FFF, sat=1; next job with small values -> sat=0.
REQ-040 out_ready held low 5 cycles on row 1 -> out_row, out_idx stable; rows 2,3 follow in order.
REQ-041 rst asserted during FLUSH -> busy=0, out_valid=0 next cycle, no done; rerun of REQ-037 job correct.
REQ-042 Negative case: A=0xFF80 (-0.5), B=0x0100, k_len=1 -> result 0xFF80; start during DRAIN ignored.
